// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: op encodings (funct3[1:0]) and FSM state type.
// Optional feature macro used by the top: DIV_FAST_SPECIAL_EN.
package div_pkg;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN:0]   dvsr,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic            unused_bits;

    // The partial remainder is always below the divisor, so its top bit never carries information.
    assign unused_bits = rem[XLEN];

    always_comb begin
        rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
        diff   = {1'b0, rem_sh} - {1'b0, dvsr};
        ge     = ~diff[XLEN+1];
        if (ge) begin
            rem_next = diff[XLEN:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh;
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle RISC-V style DIV/DIVU/REM/REMU unit (IDLE -> CALC x XLEN -> FIX -> DONE).
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC.
module seq_div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake: start_i is taken only in IDLE (busy_o=0 and not DONE); busy_o covers CALC and FIX;
    // done_o pulses for one cycle with result_o valid, and result_o then holds until the next DONE.

    localparam int             CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    div_state_e      state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic            neg_q_f;
    logic            neg_r_f;
    logic            dz_f;
    logic [XLEN:0]   rem_q;
    logic [XLEN:0]   dvsr_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] res_q;

    logic            sgn;
    logic [XLEN:0]   a_ext;
    logic [XLEN:0]   b_ext;
    logic [XLEN:0]   a_mag;
    logic [XLEN:0]   b_mag;
    logic            div_zero;
    logic            fast;
    logic [XLEN-1:0] fast_quo;
    logic [XLEN:0]   fast_rem;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] q_fix;
    logic [XLEN:0]   r_fix;
    logic [XLEN-1:0] fix_res;
    logic            unused_bits;

    // Operands widened by one bit so |-2^(XLEN-1)| is representable.
    always_comb begin
        sgn      = op_is_signed(op_i);
        a_ext    = {sgn & a_i[XLEN-1], a_i};
        b_ext    = {sgn & b_i[XLEN-1], b_i};
        a_mag    = a_ext[XLEN] ? -a_ext : a_ext;
        b_mag    = b_ext[XLEN] ? -b_ext : b_ext;
        div_zero = (b_i == '0);
        fast_quo = div_zero ? '1 : a_mag[XLEN-1:0];
        fast_rem = div_zero ? a_mag : '0;
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic ovf;
    assign ovf  = sgn && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign fast = div_zero | ovf;
`else
    assign fast = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvsr     (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // A zero divisor must yield all ones regardless of operand signs.
    always_comb begin
        q_fix   = dz_f ? '1 : (neg_q_f ? -quo_q : quo_q);
        r_fix   = neg_r_f ? -rem_q : rem_q;
        fix_res = op_is_rem(op_q) ? r_fix[XLEN-1:0] : q_fix;
    end

    assign unused_bits = r_fix[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q_f  <= 1'b0;
            neg_r_f  <= 1'b0;
            dz_f     <= 1'b0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        neg_q_f <= sgn & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        neg_r_f <= sgn & a_i[XLEN-1];
                        dz_f    <= div_zero;
                        dvsr_q  <= b_mag;
                        cnt     <= CNT_INIT;
                        if (fast) begin
                            rem_q <= fast_rem;
                            quo_q <= fast_quo;
                            state <= FIX;
                        end else begin
                            rem_q <= '0;
                            quo_q <= a_mag[XLEN-1:0];
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res_q <= fix_res;
                    state <= DONE;
                end
                DONE: begin
                    result_o <= res_q;
                    done_o   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state == CALC) || (state == FIX);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit: vector table plus busy-start, reset-abort and DONE-start sequences.
// Expected latency of special cases follows DIV_FAST_SPECIAL_EN.
module tb_seq_div_unit;
    import div_pkg::*;

    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 2;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = FULL_LAT;
`endif
    localparam int MAX_WAIT = 100;
    localparam int NVEC     = 22;

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        bit              special;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [1:0]      dbg_state_o;

    vec_t            vecs[NVEC];
    logic [XLEN-1:0] exp_q[$];
    int              n_checks = 0;
    int              n_err    = 0;

    seq_div_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input bit sp);
        vecs[i] = '{op, a, b, e, sp};
    endtask

    // driver: start is sampled by the posedge following the negedge it is raised on
    task automatic do_start(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Called #1 after the start-sampling edge; lat is the edge count at which done_o rose.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy_o ? 1 : 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_o) break;
            if (busy_o) busy_cnt++;
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int exp_lat;
        int pulses;
        int first_lat;
        logic [XLEN-1:0] got;
        logic [XLEN-1:0] exp;

        setv(0,  DIV,  32'd100,      32'd7,        32'd14,       1'b0);
        setv(1,  REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0);
        setv(2,  REMU, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0);
        setv(3,  DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0);
        setv(4,  DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        setv(5,  REM,  32'd5,        32'd0,        32'd5,        1'b1);
        setv(6,  DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        setv(7,  REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
        setv(8,  DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0);
        setv(9,  DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        setv(10, REM,  32'd100,      32'hFFFFFFF9, 32'd2,        1'b0);
        setv(11, DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1);
        setv(12, REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1);
        setv(13, DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        setv(14, REMU, 32'h80000000, 32'd0,        32'h80000000, 1'b1);
        setv(15, DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
        setv(16, REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        setv(17, DIV,  32'h80000000, 32'd2,        32'hC0000000, 1'b0);
        setv(18, DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0);
        setv(19, DIVU, 32'd9,        32'd3,        32'd3,        1'b0);
        setv(20, REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0);
        setv(21, DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0);

        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy_o}, 32'd0);
        check("reset_done",   {31'd0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_state",  {30'd0, dbg_state_o}, {30'd0, IDLE});
        @(negedge clk);
        rst = 1'b0;

        // vector table
        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(vecs[i].exp);
            do_start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, busy_cnt);
            exp_lat = vecs[i].special ? SPECIAL_LAT : FULL_LAT;
            exp = exp_q.pop_front();
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(exp_lat - 1));
            check($sformatf("v%0d_result", i), result_o, exp);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), {31'd0, done_o}, 32'd0);
        end

        // result holds after done
        repeat (5) @(posedge clk);
        #1;
        check("hold_result", result_o, vecs[NVEC-1].exp);

        // start pulsed with new operands while busy must be ignored
        do_start(DIV, 32'd100, 32'd7);
        pulses    = 0;
        first_lat = 0;
        got       = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) start_i = 1'b0;
            if (done_o) begin
                pulses++;
                if (first_lat == 0) begin
                    first_lat = k;
                    got       = result_o;
                end
            end
            if (k == 9) begin
                op_i    = DIVU;
                a_i     = 32'd50;
                b_i     = 32'd5;
                start_i = 1'b1;
            end
        end
        check("busy_start_result",  got, 32'd14);
        check("busy_start_pulses",  32'(pulses), 32'd1);
        check("busy_start_latency", 32'(first_lat), 32'(FULL_LAT));

        // reset during CALC aborts; rst also wins over a simultaneous start
        do_start(DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        check("abort_pre_busy", {31'd0, busy_o}, 32'd1);
        rst     = 1'b1;
        start_i = 1'b1;
        op_i    = DIVU;
        a_i     = 32'd9;
        b_i     = 32'd3;
        @(posedge clk);
        #1;
        check("abort_busy",   {31'd0, busy_o}, 32'd0);
        check("abort_done",   {31'd0, done_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_state",  {30'd0, dbg_state_o}, {30'd0, IDLE});
        rst     = 1'b0;
        start_i = 1'b0;
        pulses  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        do_start(DIVU, 32'd9, 32'd3);
        wait_done(lat, busy_cnt);
        check("after_abort_latency", 32'(lat), 32'(FULL_LAT));
        check("after_abort_result",  result_o, 32'd3);

        // start held high through the DONE cycle must not relaunch from DONE
        @(negedge clk);
        op_i    = DIVU;
        a_i     = 32'd20;
        b_i     = 32'd4;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, busy_cnt);
        check("held_start_latency", 32'(lat), 32'(FULL_LAT));
        check("held_start_result",  result_o, 32'd5);
        check("held_start_busy_at_done", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("held_start_idle_after", {30'd0, dbg_state_o}, {30'd0, IDLE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
